// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use interlock, branch squash,
// data-memory wait freeze and multi-cycle mult/div sequencing, plus a saturating stall counter.
//   state   | meaning
//   RUN     | normal issue; hazards resolved per cycle
//   MD_BUSY | mult/div occupying EX; front end held until r_md_cnt reaches 0
module pipeline_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             exBranchTaken,
  input  logic             exMdStart,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             idexEn,
  output logic             exmemEn,
  output logic             memwbEn,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  // The entry cycle in RUN is itself a stall, so the busy countdown covers
  // MD_LATENCY-2 further stalls plus the non-stalling exit cycle.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_md_cnt, w_md_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mem_stall, w_load_use;
  logic             w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic             w_ifid_fl, w_idex_fl, w_exmem_fl;

  assign w_mem_stall = memReq & ~memReady;
  assign w_load_use  = exMemRead & (exRt != 5'd0) &
                       ((exRt == idRs) | (idUsesRt & (exRt == idRt)));

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_ifid_fl    = 1'b0;
    w_idex_fl    = 1'b0;
    w_exmem_fl   = 1'b0;
    if (w_mem_stall) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if ((r_state == MD_BUSY && r_md_cnt != 4'd0) ||
                 (r_state == RUN && exMdStart)) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_fl = 1'b1;
      if (r_state == RUN) begin
        w_state_nxt  = MD_BUSY;
        w_md_cnt_nxt = MD_LOAD;
      end else begin
        w_md_cnt_nxt = r_md_cnt - 4'd1;
      end
    end else begin
      // Exit cycle of MD_BUSY lands here too; exMdStart is ignored for it.
      if (r_state == MD_BUSY) w_state_nxt = RUN;
      if (exBranchTaken) begin
        w_ifid_fl = 1'b1;
        w_idex_fl = 1'b1;
      end else if (w_load_use) begin
        w_pc_en   = 1'b0;
        w_ifid_en = 1'b0;
        w_idex_fl = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_md_cnt    <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pcEn       = rst & w_pc_en;
  assign ifidEn     = rst & w_ifid_en;
  assign idexEn     = rst & w_idex_en;
  assign exmemEn    = rst & w_exmem_en;
  assign memwbEn    = rst & w_memwb_en;
  assign ifidFlush  = rst & w_ifid_fl;
  assign idexFlush  = rst & w_idex_fl;
  assign exmemFlush = rst & w_exmem_fl;
  assign mdBusy     = (r_state == MD_BUSY);
  assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second narrow-counter instance exercises saturation.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs, idRt, exRt;
  logic idUsesRt, exMemRead, exBranchTaken, exMdStart, memReq, memReady;
  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, exmemFlush, mdBusy;
  logic [15:0] stallCount;
  logic pcEn2, ifidEn2, idexEn2, exmemEn2, memwbEn2, ifidFlush2, idexFlush2, exmemFlush2, mdBusy2;
  logic [1:0] stallCount2;
  int checks = 0;
  int errors = 0;

  // {pcEn,ifidEn,idexEn,exmemEn,memwbEn,ifidFlush,idexFlush,exmemFlush}
  localparam logic [7:0] NORM   = 8'b11111_000;
  localparam logic [7:0] LDUSE  = 8'b00111_010;
  localparam logic [7:0] BRANCH = 8'b11111_110;
  localparam logic [7:0] MDSTL  = 8'b00011_001;
  localparam logic [7:0] FROZEN = 8'b00000_000;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .exBranchTaken(exBranchTaken),
    .exMdStart(exMdStart), .memReq(memReq), .memReady(memReady),
    .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn), .memwbEn(memwbEn),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .mdBusy(mdBusy), .stallCount(stallCount));

  pipeline_ctrl #(.MD_LATENCY(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .exBranchTaken(exBranchTaken),
    .exMdStart(exMdStart), .memReq(memReq), .memReady(memReady),
    .pcEn(pcEn2), .ifidEn(ifidEn2), .idexEn(idexEn2), .exmemEn(exmemEn2), .memwbEn(memwbEn2),
    .ifidFlush(ifidFlush2), .idexFlush(idexFlush2), .exmemFlush(exmemFlush2),
    .mdBusy(mdBusy2), .stallCount(stallCount2));

  function automatic logic [7:0] outs();
    return {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, exmemFlush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idRs = 5'd0; idRt = 5'd0; exRt = 5'd0; idUsesRt = 1'b0; exMemRead = 1'b0;
    exBranchTaken = 1'b0; exMdStart = 1'b0; memReq = 1'b0; memReady = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    check("reset_outs", 32'(outs()), 32'(FROZEN));
    check("reset_busy", 32'(mdBusy), 32'd0);
    check("reset_cnt", 32'(stallCount), 32'd0);
    tick();
    #3 rst = 1'b1;
    #1 check("idle_outs", 32'(outs()), 32'(NORM));

    // load-use on rs: one bubble
    tick();
    exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
    #1 check("lu_rs_outs", 32'(outs()), 32'(LDUSE));
    tick();
    idle();
    #1 check("lu_rs_cnt", 32'(stallCount), 32'd1);
    check("lu_rs_after", 32'(outs()), 32'(NORM));

    // no stall: exRt==0, and rt match without idUsesRt
    exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
    #1 check("lu_r0_outs", 32'(outs()), 32'(NORM));
    exRt = 5'd7; idRt = 5'd7; idRs = 5'd3; idUsesRt = 1'b0;
    #1 check("lu_rt_unused", 32'(outs()), 32'(NORM));
    idUsesRt = 1'b1;
    #1 check("lu_rt_used", 32'(outs()), 32'(LDUSE));
    tick();
    #1 check("lu_rt_cnt", 32'(stallCount), 32'd2);
    check("sat_cnt_2", 32'(stallCount2), 32'd2);

    // branch wins over load-use
    exBranchTaken = 1'b1;
    #1 check("br_outs", 32'(outs()), 32'(BRANCH));
    tick();
    idle();
    #1 check("br_cnt", 32'(stallCount), 32'd2);

    // mem access completing in the same cycle: no stall
    memReq = 1'b1; memReady = 1'b1;
    #1 check("mem_ready_outs", 32'(outs()), 32'(NORM));
    memReq = 1'b0; memReady = 1'b0;

    // mult/div with MD_LATENCY=4: 3 stall cycles
    exMdStart = 1'b1;
    #1 check("md_entry_outs", 32'(outs()), 32'(MDSTL));
    check("md_entry_busy", 32'(mdBusy), 32'd0);
    tick();
    check("md_b1_busy", 32'(mdBusy), 32'd1);
    check("md_b1_outs", 32'(outs()), 32'(MDSTL));
    tick();
    check("md_b2_outs", 32'(outs()), 32'(MDSTL));
    tick();
    check("md_exit_busy", 32'(mdBusy), 32'd1);
    check("md_exit_outs", 32'(outs()), 32'(NORM));
    check("md_exit_cnt", 32'(stallCount), 32'd5);
    tick();
    check("md_no_retrig", 32'(mdBusy), 32'd0);
    check("md_done_cnt", 32'(stallCount), 32'd5);
    check("sat_cnt_hold", 32'(stallCount2), 32'd3);
    exMdStart = 1'b0;

    // mult/div with 3-cycle memory wait in the middle: 6 stall cycles
    #1 exMdStart = 1'b1;
    tick();
    check("mdm_cnt_entry", 32'(stallCount), 32'd6);
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mdm_frozen_outs", 32'(outs()), 32'(FROZEN));
      tick();
      check("mdm_frozen_busy", 32'(mdBusy), 32'd1);
    end
    check("mdm_cnt_frozen", 32'(stallCount), 32'd9);
    memReq = 1'b0;
    #1 check("mdm_resume1", 32'(outs()), 32'(MDSTL));
    tick();
    check("mdm_resume2", 32'(outs()), 32'(MDSTL));
    tick();
    check("mdm_exit_outs", 32'(outs()), 32'(NORM));
    check("mdm_total", 32'(stallCount), 32'd11);
    tick();
    exMdStart = 1'b0;
    check("mdm_done_busy", 32'(mdBusy), 32'd0);
    check("mdm_done_cnt", 32'(stallCount), 32'd11);

    // async reset in the middle of MD_BUSY
    #1 exMdStart = 1'b1;
    tick();
    check("rst_pre_busy", 32'(mdBusy), 32'd1);
    #2 rst = 1'b0;
    #1 check("rst_async_outs", 32'(outs()), 32'(FROZEN));
    check("rst_async_busy", 32'(mdBusy), 32'd0);
    check("rst_async_cnt", 32'(stallCount), 32'd0);
    idle();
    tick();
    #2 rst = 1'b1;
    #1 check("rst_rel_outs", 32'(outs()), 32'(NORM));
    tick();
    check("rst_rel_busy", 32'(mdBusy), 32'd0);
    check("rst_rel_cnt", 32'(stallCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
